// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with a 2-flop input synchroniser, false-start rejection, framing check and valid/ack handshake.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Sample_Clk,
  input  logic                 Reset,
  input  logic                 serin,
  input  logic [DIV_WIDTH-1:0] Divider,
  input  logic                 Data_Ack,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic                 Frame_Err,
  output logic                 Parity_Err,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  logic                 r_sync1, r_sync2;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid, r_ferr, r_perr, r_overrun, r_busy;

  logic                 w_rx_s;
  logic [DIV_WIDTH-1:0] w_div_clamped;
  logic [DIV_WIDTH-1:0] w_cnt_next;
  logic                 w_accept;
  logic                 w_par_err;

  assign w_rx_s        = r_sync2;
  assign w_div_clamped = (Divider < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : Divider;
  assign w_cnt_next    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  // An acknowledge in the completion cycle frees the slot for the new word.
  assign w_accept      = !r_valid || Data_Ack;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  assign w_par_err = (^{r_shift, r_par_bit}) != 1'(PARITY_ODD);
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge Sample_Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_div_q    <= DIV_WIDTH'(4);
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_sync1 <= serin;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_next;

      if (Data_Ack && r_valid) begin
        r_valid   <= 1'b0;
        r_ferr    <= 1'b0;
        r_perr    <= 1'b0;
        r_overrun <= 1'b0;
      end

      // NOTE: the frame-completion assignments below come after the ack clear, so the later non-blocking write wins when both happen in one cycle.
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
            r_div_q <= w_div_clamped;
            r_cnt   <= DIV_WIDTH'(1);  // counter holds cycles elapsed since the start edge
          end
        end
        S_START: begin
          if (r_cnt >= (r_div_q >> 1)) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_cnt     <= DIV_WIDTH'(1);
              r_bit_cnt <= '0;
            end
          end
        end
        S_DATA: begin
          if (r_cnt >= r_div_q) begin
            r_cnt   <= DIV_WIDTH'(1);
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt >= r_div_q) begin
            r_cnt     <= DIV_WIDTH'(1);
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (r_cnt >= r_div_q) begin
            if (w_accept) begin
              r_data_out <= r_shift;
              r_valid    <= 1'b1;
              r_ferr     <= !w_rx_s;
              r_perr     <= w_par_err;
              r_overrun  <= 1'b0;
            end else begin
              r_overrun  <= 1'b1;
            end
            r_state <= w_rx_s ? S_IDLE : S_BREAK;
            r_busy  <= !w_rx_s;
          end
        end
        S_BREAK: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Data_Out   = r_data_out;
  assign Data_Valid = r_valid;
  assign Frame_Err  = r_ferr;
  assign Parity_Err = r_perr;
  assign Overrun    = r_overrun;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard testbench for uart_rx_cfg: frames are driven bit-by-bit, expected words queued on send and compared on Data_Valid.
module tb_uart_rx_cfg;
  localparam int DATA_BITS  = 8;
  localparam int DIV_WIDTH  = 16;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 serin = 1'b1;
  logic [DIV_WIDTH-1:0] divider = 16'd16;
  logic                 data_ack = 1'b0;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid, frame_err, parity_err, overrun, busy;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  uart_rx_cfg #(.DATA_BITS(DATA_BITS), .DIV_WIDTH(DIV_WIDTH), .PARITY_ODD(PARITY_ODD)) dut (
    .Sample_Clk(clk),
    .Reset     (rst),
    .serin     (serin),
    .Divider   (divider),
    .Data_Ack  (data_ack),
    .Data_Out  (data_out),
    .Data_Valid(data_valid),
    .Frame_Err (frame_err),
    .Parity_Err(parity_err),
    .Overrun   (overrun),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int eff_div(input logic [DIV_WIDTH-1:0] d);
    return (d < 4) ? 4 : int'(d);
  endfunction

  // Edge (counted from the edge before serin falls) on which the completed frame appears.
  function automatic int comp_edge(input int d);
    return 3 + d / 2 + (DATA_BITS + 1 + PAR_EN) * d;
  endfunction

  function automatic logic good_par(input logic [DATA_BITS-1:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

  function automatic logic exp_perr(input logic [DATA_BITS-1:0] d, input logic p);
    return (PAR_EN != 0) && ((^{d, p}) != 1'(PARITY_ODD));
  endfunction

  // Caller is positioned just after a rising edge; serin is left at the stop value.
  task automatic drive_bits(input logic [DATA_BITS-1:0] d, input logic p, input logic stop, input int bc);
    serin = 1'b0;
    repeat (bc) @(posedge clk);
    #1;
    for (int i = 0; i < DATA_BITS; i++) begin
      serin = d[i];
      repeat (bc) @(posedge clk);
      #1;
    end
    if (PAR_EN != 0) begin
      serin = p;
      repeat (bc) @(posedge clk);
      #1;
    end
    serin = stop;
    repeat (bc) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DATA_BITS-1:0] d, input logic p, input logic stop);
    exp_t e;
    e.data = d;
    e.ferr = !stop;
    e.perr = exp_perr(d, p);
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic p, input logic stop, input bit push);
    if (push) push_exp(d, p, stop);
    @(posedge clk);
    #1;
    drive_bits(d, p, stop, eff_div(divider));
  endtask

  task automatic wait_valid(input string name);
    int   waited;
    exp_t e;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!data_valid && waited < 4000);
    n_checks++;
    if (!data_valid) begin
      n_errors++;
      $display("FAIL %s valid_timeout: Data_Valid=%b after %0d cycles, required 1", name, data_valid, waited);
    end else if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s unexpected_word: Data_Out=%h with empty scoreboard", name, data_out);
    end else begin
      e = sb.pop_front();
      n_checks += 3;
      if (data_out !== e.data) begin
        n_errors++; $display("FAIL %s data: got %h, required %h", name, data_out, e.data);
      end
      if (frame_err !== e.ferr) begin
        n_errors++; $display("FAIL %s frame_err: got %b, required %b", name, frame_err, e.ferr);
      end
      if (parity_err !== e.perr) begin
        n_errors++; $display("FAIL %s parity_err: got %b, required %b", name, parity_err, e.perr);
      end
    end
  endtask

  task automatic ack();
    @(posedge clk);
    #1 data_ack = 1'b1;
    @(posedge clk);
    #1 data_ack = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name, input logic [DATA_BITS-1:0] exp_data);
    @(negedge clk);
    n_checks += 6;
    if (data_out !== exp_data) begin n_errors++; $display("FAIL %s data_out: got %h, required %h", name, data_out, exp_data); end
    if (data_valid !== 1'b0) begin n_errors++; $display("FAIL %s data_valid: got %b, required 0", name, data_valid); end
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL %s frame_err: got %b, required 0", name, frame_err); end
    if (parity_err !== 1'b0) begin n_errors++; $display("FAIL %s parity_err: got %b, required 0", name, parity_err); end
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL %s overrun: got %b, required 0", name, overrun); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL %s busy: got %b, required 0", name, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_idle_outputs("reset", '0);
    rst = 1'b0;
  endtask

  task automatic test_basic_timing();
    int ce;
    divider = 16'd16;
    ce = comp_edge(16);
    push_exp(8'hA5, good_par(8'hA5), 1'b1);
    @(posedge clk);
    #1;
    fork
      drive_bits(8'hA5, good_par(8'hA5), 1'b1, 16);
      begin
        repeat (ce - 1) @(posedge clk);
        #1;
        n_checks += 2;
        if (data_valid !== 1'b0) begin n_errors++; $display("FAIL basic early_valid: got %b, required 0", data_valid); end
        if (busy !== 1'b1) begin n_errors++; $display("FAIL basic busy_before: got %b, required 1", busy); end
        @(posedge clk);
        #1;
        n_checks += 2;
        if (data_valid !== 1'b1) begin n_errors++; $display("FAIL basic valid_edge: got %b, required 1", data_valid); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL basic busy_after: got %b, required 0", busy); end
      end
    join
    wait_valid("basic");
    ack();
    check_idle_outputs("basic_ack", 8'hA5);
  endtask

  task automatic test_false_start();
    @(posedge clk);
    #1 serin = 1'b0;
    repeat (5) @(posedge clk);
    #1 serin = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL false_start busy_during: got %b, required 1", busy); end
    repeat (30) @(posedge clk);
    check_idle_outputs("false_start", 8'hA5);
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, good_par(8'h3C), 1'b1, 1'b1);
    wait_valid("overrun_first");
    send_frame(8'h7E, good_par(8'h7E), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    n_checks += 3;
    if (data_out !== 8'h3C) begin n_errors++; $display("FAIL overrun data_kept: got %h, required 3c", data_out); end
    if (data_valid !== 1'b1) begin n_errors++; $display("FAIL overrun valid: got %b, required 1", data_valid); end
    if (overrun !== 1'b1) begin n_errors++; $display("FAIL overrun flag: got %b, required 1", overrun); end
    ack();
    check_idle_outputs("overrun_ack", 8'h3C);
  endtask

  task automatic test_break();
    send_frame(8'h55, good_par(8'h55), 1'b0, 1'b1);
    wait_valid("break");
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL break busy_held: got %b, required 1", busy); end
    ack();
    repeat (48) @(negedge clk);
    n_checks += 2;
    if (data_valid !== 1'b0) begin n_errors++; $display("FAIL break retrigger: Data_Valid=%b, required 0", data_valid); end
    if (busy !== 1'b1) begin n_errors++; $display("FAIL break busy_low_line: got %b, required 1", busy); end
    @(posedge clk);
    #1 serin = 1'b1;
    repeat (4) @(posedge clk);
    check_idle_outputs("break_release", 8'h55);
  endtask

  task automatic test_ack_same_cycle();
    int ce;
    ce = comp_edge(16);
    send_frame(8'h11, good_par(8'h11), 1'b1, 1'b1);
    wait_valid("same_cycle_old");
    push_exp(8'h22, good_par(8'h22), 1'b1);
    @(posedge clk);
    #1;
    fork
      drive_bits(8'h22, good_par(8'h22), 1'b1, 16);
      begin
        repeat (ce - 1) @(posedge clk);
        #1 data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
      end
    join
    wait_valid("same_cycle_new");
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL same_cycle overrun: got %b, required 0", overrun); end
    ack();
  endtask

  task automatic test_back_to_back();
    push_exp(8'h81, good_par(8'h81), 1'b1);
    push_exp(8'h42, good_par(8'h42), 1'b1);
    @(posedge clk);
    #1;
    fork
      begin
        drive_bits(8'h81, good_par(8'h81), 1'b1, 16);
        drive_bits(8'h42, good_par(8'h42), 1'b1, 16);
      end
      begin
        wait_valid("b2b_first");
        ack();
        wait_valid("b2b_second");
        ack();
      end
    join
  endtask

  task automatic test_divider();
    divider = 16'd2;
    send_frame(8'h96, good_par(8'h96), 1'b1, 1'b1);
    wait_valid("min_divider");
    ack();
    divider = 16'd12;
    push_exp(8'h6B, good_par(8'h6B), 1'b1);
    @(posedge clk);
    #1;
    fork
      drive_bits(8'h6B, good_par(8'h6B), 1'b1, 12);
      begin
        repeat (40) @(posedge clk);
        #1 divider = 16'd5;
      end
    join
    wait_valid("divider_latched");
    ack();
    divider = 16'd16;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    wait_valid("parity_bad");
    ack();
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    wait_valid("parity_good");
    ack();
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [DATA_BITS-1:0] d;
    d = 8'hF0;
    send_frame(8'h99, good_par(8'h99), 1'b1, 1'b1);
    wait_valid("pre_reset");
    @(posedge clk);
    #1 serin = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 serin = d[i];
      repeat ((i == 3) ? 8 : 16) @(posedge clk);
    end
    #1 rst = 1'b1;
    serin = 1'b1;
    #1;
    n_checks += 3;
    if (data_out !== '0) begin n_errors++; $display("FAIL mid_reset data_out: got %h, required 00", data_out); end
    if (data_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset valid: got %b, required 0", data_valid); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_reset busy: got %b, required 0", busy); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    check_idle_outputs("post_reset", '0);
    send_frame(8'hC3, good_par(8'hC3), 1'b1, 1'b1);
    wait_valid("after_reset");
    ack();
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_false_start();
    test_overrun();
    test_break();
    test_ack_same_cycle();
    test_back_to_back();
    test_divider();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d words never delivered, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: the next generation of the single-rate 8N1 receiver on the ADC control link. Sits between the host serial input pin and the command decoder, sampled on `Sample_Clk`. Adds configurable data width, input synchronisation, false-start rejection, stop-bit framing check, a valid/acknowledge handshake with overrun detection, and optional parity checking.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5..9, sent LSB first.
- `DIV_WIDTH`, 16: width of `Divider`.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even. Used only with `UART_RX_PARITY_EN`.
- `Sample_Clk`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `serin`  in  1  asynchronous serial line; idles high.
- `Divider`  in  DIV_WIDTH  `Sample_Clk` cycles per bit; values below 4 are treated as 4.
- `Data_Ack`  in  1  consumer acknowledge; clears `Data_Valid`, `Overrun`, `Frame_Err`, `Parity_Err`.
- `Data_Out`  out  DATA_BITS  last accepted word.
- `Data_Valid`  out  1  level; high from word acceptance until `Data_Ack`.
- `Frame_Err`  out  1  stop bit of the accepted word sampled low.
- `Parity_Err`  out  1  parity mismatch on the accepted word; constant 0 without `UART_RX_PARITY_EN`.
- `Overrun`  out  1  sticky; a frame completed while `Data_Valid` was high.
- `Busy`  out  1  high in any state except IDLE.

## Operation
- `serin` passes through a 2-flop synchroniser, reset to 1. All logic below uses the synchronised value `rx_s`.
- At frame start, `Divider` (clamped to at least 4) is latched as `div_q`. Changes to `Divider` mid-frame are ignored.
- States:
  - IDLE: `rx_s`==0 -> START, counter cleared.
  - START: after `div_q>>1` cycles, sample `rx_s`. If 1, this is a false start -> IDLE with no outputs changed. If 0 -> DATA.
  - DATA: sample every `div_q` cycles and shift in LSB first. After `DATA_BITS` samples -> PARITY if enabled, else STOP.
  - PARITY: one sample, `div_q` cycles after the last data bit.
  - STOP: one sample, `div_q` cycles after the previous sample, then the frame completes.
    - Stop sampled 1 -> IDLE.
    - Stop sampled 0 -> BREAK.
  - BREAK: wait for `rx_s`==1, then IDLE. This prevents a held-low line from retriggering.
- Frame completion with `Data_Valid`==0:
  - Update `Data_Out`, `Frame_Err` and `Parity_Err`; set `Data_Valid`.
  - Frame errors and parity errors still deliver the data.
- Frame completion with `Data_Valid`==1:
  - Discard the new word and set `Overrun`.
  - `Data_Out` and the error flags are unchanged.
- `Data_Ack` with `Data_Valid`==1 clears `Data_Valid`, `Frame_Err`, `Parity_Err` and `Overrun` on the next edge.
- `Data_Ack` with `Data_Valid`==0 is ignored.
- `Data_Ack` in the same cycle as frame completion: the acknowledge applies to the old word, and the new word is accepted without overrun. Net result: `Data_Valid` stays 1, `Data_Out` holds the new word, `Overrun`=0.
- Bit counter width is clog2(DATA_BITS+1). The cycle counter is DIV_WIDTH bits; it is compared with `>=` and never wraps.

## Timing
- Reset values:
  - `Data_Out`=0.
  - `Data_Valid`=`Frame_Err`=`Parity_Err`=`Overrun`=`Busy`=0.
  - Synchroniser flops = 1; state = IDLE.
- Reset mid-frame aborts the frame immediately and delivers no partial word.
- Input latency: 2 cycles from a `serin` edge to `rx_s`.
- Cycle numbering: cycle 0 is the first cycle with `rx_s`==0 in IDLE.
  - Start sample at cycle `div_q>>1`.
  - Data bit k (k = 0..DATA_BITS-1) sampled at `(div_q>>1)+(k+1)*div_q`.
  - Parity sampled at `(div_q>>1)+(DATA_BITS+1)*div_q`.
  - Stop sampled one `div_q` after the previous sample.
- Outputs update on the edge after the stop sample. `Busy` falls on that same edge when the stop bit is 1.
- Back-to-back frames: IDLE is re-entered in time to detect a start bit immediately after a one-bit stop.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists and one parity bit is expected between data and stop.
  - `Parity_Err` is computed per `PARITY_ODD` (parity over data and parity bit).
- `UART_RX_PARITY_EN` not defined:
  - No PARITY state; the frame format is 1 start, `DATA_BITS` data, 1 stop.
  - `Parity_Err` is tied to 0, and `PARITY_ODD` is unused.

## Test plan
- 8N1, `Divider`=16, send 0xA5:
  - Start sample at cycle 8, stop sample at cycle 152.
  - `Data_Valid` rises at cycle 153 with `Data_Out`=0xA5 and all error flags 0.
- Glitch low for 5 cycles with `Divider`=16 -> false start rejected; `Busy` returns to 0 and no outputs change.
- Send 0x3C, then 0x7E with no `Data_Ack` -> `Data_Out`=0x3C and `Overrun`=1. A following `Data_Ack` clears all flags.
- Send 0x55 with the stop bit forced low and the line held low for 3 bit times:
  - `Data_Out`=0x55, `Frame_Err`=1.
  - No new frame until the line returns high.
- `UART_RX_PARITY_EN`, `PARITY_ODD`=0, `Divider`=16, send 0x01 with parity bit 0 -> `Parity_Err`=1. Resend with parity bit 1 -> `Parity_Err`=0.
- `Reset` pulsed during data bit 3 -> all outputs 0 and state IDLE. The next clean frame 0xC3 is received correctly.
